// File: rtl/if_prefetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0: what decode sees whenever no instruction is presented
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Instruction-memory channel: valid/ready request, in-order variable-latency response.
interface if_prefetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_rsp_valid;
    logic [31:0]      imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_prefetch_unit_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO of {pc, instr}; head is read straight from
// the storage registers. DEPTH must be a power of two so the pointers wrap naturally.
module if_fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output fetch_entry_t               head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count_reg != '0) && !flush;
    assign do_push = push && !flush && ((count_reg != CW'(DEPTH)) || do_pop);

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (do_push && !do_pop) begin
            count_next = count_reg + CW'(1);
        end else if (do_pop && !do_push) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (flush) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (do_pop) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
            end
        end
    end

    // Storage needs no reset: an entry is only observed after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign head  = mem[rd_ptr_reg];

endmodule

// File: rtl/if_prefetch_unit.sv
// RV32I fetch front end: owns the fetch PC, issues credited requests, buffers responses.
// Optional IF_PREFETCH_BYPASS_EN lets a response into an empty FIFO drive if_* the same cycle.
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    if_prefetch_unit_if.master       imem,
    input  logic                     redirect_valid,
    input  logic [WIDTH-1:0]         redirect_pc,
    input  logic                     stall,
    output logic                     if_valid,
    output logic [WIDTH-1:0]         if_pc,
    output logic [WIDTH-1:0]         if_pc_plus_4,
    output logic [31:0]              if_instruction
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;

    logic [WIDTH-1:0] fetch_pc_reg;
    logic [WIDTH-1:0] fetch_pc_next;
    logic [WIDTH-1:0] rsp_pc_reg;
    logic [WIDTH-1:0] rsp_pc_next;
    logic [CW-1:0]    inflight_reg;
    logic [CW-1:0]    inflight_next;
    logic [CW-1:0]    drop_reg;
    logic [CW-1:0]    drop_next;

    logic             credit_ok;
    logic             req_valid;
    logic             req_fire;
    logic             rsp_fire;
    logic             rsp_keep;
    logic             bypass;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    fetch_entry_t     fifo_head;
    fetch_entry_t     rsp_entry;
    fetch_entry_t     out_entry;

    // A response with nothing outstanding is a protocol error and is ignored entirely.
    assign rsp_fire = imem.imem_rsp_valid && (inflight_reg != '0);
    assign rsp_keep = rsp_fire && (drop_reg == '0) && !redirect_valid;

    // Credit covers both outstanding requests and buffered words, so pushes never overflow.
    assign credit_ok = (SW'(inflight_reg) + SW'(fifo_count)) < SW'(DEPTH);
    assign req_valid = reset_n && credit_ok && !redirect_valid;
    assign req_fire  = req_valid && imem.imem_req_ready;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = fetch_pc_reg;

    assign rsp_entry = '{pc: rsp_pc_reg, instr: imem.imem_rsp_data};

`ifdef IF_PREFETCH_BYPASS_EN
    assign bypass    = rsp_keep && fifo_empty;
    assign out_entry = fifo_empty ? rsp_entry : fifo_head;
`else
    assign bypass    = 1'b0;
    assign out_entry = fifo_head;
`endif

    assign if_valid       = !fifo_empty || bypass;
    assign if_pc          = if_valid ? out_entry.pc : '0;
    assign if_instruction = if_valid ? out_entry.instr : NOP_INST;
    assign if_pc_plus_4   = if_pc + WIDTH'(4);

    // A bypassed word that decode accepts this cycle never needs a FIFO slot.
    assign fifo_push = rsp_keep && !(bypass && !stall);
    assign fifo_pop  = !fifo_empty && !stall;

    if_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (fifo_push),
        .push_entry (rsp_entry),
        .pop        (fifo_pop),
        .flush      (redirect_valid),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .head       (fifo_head)
    );

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        rsp_pc_next   = rsp_pc_reg;
        inflight_next = inflight_reg;
        drop_next     = drop_reg;
        if (redirect_valid) begin
            // Everything still outstanding is stale; a same-cycle response is already gone.
            fetch_pc_next = redirect_pc;
            rsp_pc_next   = redirect_pc;
            inflight_next = inflight_reg - CW'(rsp_fire);
            drop_next     = inflight_reg - CW'(rsp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + WIDTH'(4);
            end
            inflight_next = inflight_reg + CW'(req_fire) - CW'(rsp_fire);
            if (rsp_fire && (drop_reg != '0)) begin
                drop_next = drop_reg - CW'(1);
            end
            if (rsp_keep) begin
                rsp_pc_next = rsp_pc_reg + WIDTH'(4);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_reg <= RESET_PC;
            rsp_pc_reg   <= RESET_PC;
            inflight_reg <= '0;
            drop_reg     <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            rsp_pc_reg   <= rsp_pc_next;
            inflight_reg <= inflight_next;
            drop_reg     <= drop_next;
        end
    end

endmodule
